factor_round_ctrl: RTL and testbench
====================================

# factor_round_ctrl

Round controller for the 1P factorization game. Consumes the start strobe `RUN_IN` and the random digit `NUM` produced by the ready/random block. It runs one timed round in which the player enters prime factors one at a time. It drives the 4-bit `STATE` bus back to the ready block, so that block can clear its ready latch on the final states, and exposes target, remainder and countdown values for the display logic.

## Interface

Parameters:
- `CLK_HZ`, 50_000_000: clock frequency. The 1 Hz tick fires every `CLK_HZ` cycles.
- `TIME_LIMIT`, 9: seconds allowed per round, range 1–15.
- `HOLD_SEC`, 3: seconds `WIN`/`LOSE` is held before returning to `IDLE`, range 1–15.

Ports:
- `CLK`  in  1  system clock
- `RST`  in  1  reset, asynchronous, active-low
- `RUN_IN`  in  1  start level from the ready block
- `NUM`  in  4  random digit, sampled at round start
- `ANS_VALID`  in  1  one-cycle pulse: the player submits a factor
- `ANS`  in  4  submitted factor value
- `STATE`  out  4  round state code
- `TARGET`  out  5  number to factor for this round
- `REMAIN`  out  5  unfactored remainder
- `SEC_LEFT`  out  4  seconds remaining
- `HIT`  out  1  one-cycle pulse on each accepted factor

## Operation

- `STATE` codes:
  - `IDLE`=0
  - `LOAD`=1
  - `PLAY`=2
  - `WIN`=3
  - `LOSE`=4
  - codes 5–15 are unused and are never driven.
- Target table, indexed by `NUM` mod 10 (so `NUM` 10–15 map to indices 0–5): 4, 6, 8, 9, 10, 12, 14, 15, 16, 18.
- Transitions:
  - `IDLE` -> `LOAD` on a rising edge of `RUN_IN`. The edge detector uses a registered copy of `RUN_IN`. The edge register resets to 1, so a `RUN_IN` that is already high at reset release does not start a round.
  - `LOAD` (exactly 1 cycle):
    - `TARGET` and `REMAIN` are loaded with the table value.
    - `SEC_LEFT` is loaded with `TIME_LIMIT`.
    - The prescaler is cleared.
    - Next state is `PLAY`.
  - `PLAY`, on `ANS_VALID`:
    - An answer is accepted when `ANS` is in {2, 3, 5, 7} and divides `REMAIN` exactly. On acceptance: `REMAIN` <= `REMAIN`/`ANS`, and `HIT` pulses on the next cycle. If the new `REMAIN`==1, next state is `WIN`.
    - Any other `ANS` (including 0, 1, composite, or a non-divisor) sends the round to `LOSE`. `REMAIN` is unchanged.
  - `PLAY`, on a 1 Hz tick: `SEC_LEFT` decrements. A tick while `SEC_LEFT`==1 sets it to 0 and goes to `LOSE`.
  - `WIN`/`LOSE`:
    - The prescaler is cleared on entry.
    - The state holds for `HOLD_SEC` ticks, then returns to `IDLE`.
    - `TARGET`, `REMAIN` and `SEC_LEFT` are frozen.
    - `ANS_VALID` and `RUN_IN` edges are ignored.
- `ANS_VALID` is ignored outside `PLAY`.
- Division is by constant per factor value (a case on `ANS`); no generic divider. `REMAIN` never exceeds 18.

## Timing

- Reset values of all outputs:
  - `STATE`=0 (`IDLE`)
  - `TARGET`=0
  - `REMAIN`=0
  - `SEC_LEFT`=0
  - `HIT`=0
- Internal reset values: prescaler=0, hold counter=0.
- Reset asserted mid-round: immediate return to `IDLE` with all outputs at reset values.
- Latency:
  - `RUN_IN` rise at cycle n: `STATE`=`LOAD` at n+1, `PLAY` at n+2, with `TARGET` valid from n+2.
  - `ANS_VALID` at cycle m: `REMAIN`, `STATE` and `HIT` update at m+1.
- Tick: the prescaler counts 0..`CLK_HZ`-1 and ticks on the terminal count. The first tick in `PLAY` falls `CLK_HZ` cycles after entering `PLAY`.
- Simultaneous `ANS_VALID` and tick in `PLAY`:
  - The answer is evaluated first.
  - If the answer causes `WIN` or `LOSE`, the tick is discarded.
  - Otherwise both apply in the same cycle: `REMAIN` updates and `SEC_LEFT` decrements. If that tick is the terminal one (`SEC_LEFT`==1), the result is `LOSE` even though the answer was accepted, and `HIT` still pulses.
- `RUN_IN` falling during `PLAY` has no effect.

## Test plan

All scenarios run with `CLK_HZ`=10, `TIME_LIMIT`=3, `HOLD_SEC`=2.

- **Reset:** assert `RST` low mid-`PLAY` -> all outputs are 0 in the same cycle and `STATE` is 0 after release.
- **Win path:** `NUM`=5, `RUN_IN` rises -> `TARGET`=12. Then `ANS` 2, 2, 3 -> `REMAIN` goes 6, 3, 1; `HIT` pulses 3 times; `STATE`=3. After 20 cycles, `STATE`=0.
- **Wrong factor:** `NUM`=3 (`TARGET`=9), `ANS`=2 -> `STATE`=4 and `REMAIN`=9. `ANS`=9 or `ANS`=1 gives the same result.
- **Timeout:** `NUM`=0 (`TARGET`=4), no answers -> `SEC_LEFT` reads 3, 2, 1 at 10-cycle intervals, then 0 together with `STATE`=4 exactly 30 cycles after entering `PLAY`.
- **Simultaneous answer and tick:**
  - At `SEC_LEFT`=1, a final correct factor arriving in the same cycle as the tick -> `STATE`=3 (`WIN`).
  - A non-final correct factor in that same cycle -> `STATE`=4 (`LOSE`), with `HIT` pulsing.
- **Edge handling:**
  - `RUN_IN` held high through reset release -> no round starts.
  - `NUM`=12 -> index 2, `TARGET`=8.
  - `ANS_VALID` pulses while in `IDLE` or `WIN` -> no output change.

Source files
------------

// File: rtl/factor_round_ctrl.sv
// Round controller for the factorization game: loads a target, accepts prime factors, times the round.
// Latency: RUN_IN rise -> LOAD next cycle, PLAY the cycle after; answers update REMAIN/STATE/HIT one cycle later.
// Backpressure: none; ANS_VALID is a fire-and-forget pulse, ignored outside PLAY.
module factor_round_ctrl #(
  parameter int CLK_HZ     = 50_000_000,
  parameter int TIME_LIMIT = 9,
  parameter int HOLD_SEC   = 3
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       RUN_IN,
  input  logic [3:0] NUM,
  input  logic       ANS_VALID,
  input  logic [3:0] ANS,
  output logic [3:0] STATE,
  output logic [4:0] TARGET,
  output logic [4:0] REMAIN,
  output logic [3:0] SEC_LEFT,
  output logic       HIT
);

  localparam int PW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;

  typedef enum logic [3:0] {
    S_IDLE = 4'd0,
    S_LOAD = 4'd1,
    S_PLAY = 4'd2,
    S_WIN  = 4'd3,
    S_LOSE = 4'd4
  } state_t;

  state_t         state_q, state_nxt;
  logic [4:0]     target_q, target_nxt;
  logic [4:0]     remain_q, remain_nxt;
  logic [3:0]     sec_q, sec_nxt;
  logic           hit_q, hit_nxt;
  logic [3:0]     hold_q, hold_nxt;
  logic [PW-1:0]  presc_q;
  logic           presc_clr;
  logic           tick;
  logic           run_q;
  logic           run_rise;
  logic [5:0]     factor;
  logic           factor_ok;
  logic [4:0]     factor_q;

  // Target lookup indexed by NUM mod 10 (10..15 fold onto 0..5).
  function automatic logic [4:0] target_of(input logic [3:0] num);
    logic [4:0] t;
    t = 5'd4;
    case (num)
      4'd0, 4'd10: t = 5'd4;
      4'd1, 4'd11: t = 5'd6;
      4'd2, 4'd12: t = 5'd8;
      4'd3, 4'd13: t = 5'd9;
      4'd4, 4'd14: t = 5'd10;
      4'd5, 4'd15: t = 5'd12;
      4'd6:        t = 5'd14;
      4'd7:        t = 5'd15;
      4'd8:        t = 5'd16;
      4'd9:        t = 5'd18;
      default:     t = 5'd4;
    endcase
    return t;
  endfunction

  // Constant division by one of the allowed primes; returns {divides, quotient}.
  // REMAIN never exceeds 18, so each prime only needs its few multiples listed.
  function automatic logic [5:0] try_factor(input logic [4:0] rem, input logic [3:0] f);
    logic [5:0] r;
    r = 6'd0;
    case (f)
      4'd2: if (!rem[0]) r = {1'b1, 1'b0, rem[4:1]};
      4'd3: begin
        case (rem)
          5'd3:    r = {1'b1, 5'd1};
          5'd6:    r = {1'b1, 5'd2};
          5'd9:    r = {1'b1, 5'd3};
          5'd12:   r = {1'b1, 5'd4};
          5'd15:   r = {1'b1, 5'd5};
          5'd18:   r = {1'b1, 5'd6};
          default: r = 6'd0;
        endcase
      end
      4'd5: begin
        case (rem)
          5'd5:    r = {1'b1, 5'd1};
          5'd10:   r = {1'b1, 5'd2};
          5'd15:   r = {1'b1, 5'd3};
          default: r = 6'd0;
        endcase
      end
      4'd7: begin
        case (rem)
          5'd7:    r = {1'b1, 5'd1};
          5'd14:   r = {1'b1, 5'd2};
          default: r = 6'd0;
        endcase
      end
      default: r = 6'd0;
    endcase
    return r;
  endfunction

  assign factor    = try_factor(remain_q, ANS);
  assign factor_ok = factor[5];
  assign factor_q  = factor[4:0];

  assign tick     = (presc_q == PW'(CLK_HZ - 1));
  assign run_rise = RUN_IN & ~run_q;

  // Start-edge history; resets high so a level already present at release is not an edge.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) run_q <= 1'b1;
    else      run_q <= RUN_IN;
  end

  // 1 Hz prescaler, restarted on round load and on entry to the result states.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST)                  presc_q <= '0;
    else if (presc_clr || tick) presc_q <= '0;
    else                       presc_q <= presc_q + 1'b1;
  end

  // State and datapath registers.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q  <= S_IDLE;
      target_q <= '0;
      remain_q <= '0;
      sec_q    <= '0;
      hit_q    <= 1'b0;
      hold_q   <= '0;
    end else begin
      state_q  <= state_nxt;
      target_q <= target_nxt;
      remain_q <= remain_nxt;
      sec_q    <= sec_nxt;
      hit_q    <= hit_nxt;
      hold_q   <= hold_nxt;
    end
  end

  // Next-state logic: the answer is resolved before the tick, and a round-ending answer swallows the tick.
  always_comb begin
    state_nxt  = state_q;
    target_nxt = target_q;
    remain_nxt = remain_q;
    sec_nxt    = sec_q;
    hit_nxt    = 1'b0;
    hold_nxt   = hold_q;
    presc_clr  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (run_rise) state_nxt = S_LOAD;
      end

      S_LOAD: begin
        target_nxt = target_of(NUM);
        remain_nxt = target_of(NUM);
        sec_nxt    = 4'(TIME_LIMIT);
        presc_clr  = 1'b1;
        state_nxt  = S_PLAY;
      end

      S_PLAY: begin
        hold_nxt = '0;
        if (ANS_VALID) begin
          if (factor_ok) begin
            remain_nxt = factor_q;
            hit_nxt    = 1'b1;
            if (factor_q == 5'd1) begin
              state_nxt = S_WIN;
            end else if (tick) begin
              sec_nxt = sec_q - 1'b1;
              if (sec_q == 4'd1) state_nxt = S_LOSE;
            end
          end else begin
            state_nxt = S_LOSE;
          end
        end else if (tick) begin
          sec_nxt = sec_q - 1'b1;
          if (sec_q == 4'd1) state_nxt = S_LOSE;
        end
        if (state_nxt != S_PLAY) presc_clr = 1'b1;
      end

      S_WIN, S_LOSE: begin
        if (tick) begin
          if (hold_q == 4'(HOLD_SEC - 1)) begin
            hold_nxt  = '0;
            state_nxt = S_IDLE;
          end else begin
            hold_nxt = hold_q + 1'b1;
          end
        end
      end

      default: state_nxt = S_IDLE;
    endcase
  end

  assign STATE    = state_q;
  assign TARGET   = target_q;
  assign REMAIN   = remain_q;
  assign SEC_LEFT = sec_q;
  assign HIT      = hit_q;

endmodule

// File: tb/tb_factor_round_ctrl.sv
// Directed bench for factor_round_ctrl with CLK_HZ=10, TIME_LIMIT=3, HOLD_SEC=2.
// Inputs change 1 time unit after the rising edge; outputs are sampled at the same point.
// Expected values are hand-derived constants.
module tb_factor_round_ctrl;

  logic       CLK = 1'b0;
  logic       RST;
  logic       RUN_IN;
  logic [3:0] NUM;
  logic       ANS_VALID;
  logic [3:0] ANS;
  logic [3:0] STATE;
  logic [4:0] TARGET;
  logic [4:0] REMAIN;
  logic [3:0] SEC_LEFT;
  logic       HIT;

  int checks = 0;
  int errors = 0;

  always #5 CLK = ~CLK;

  factor_round_ctrl #(
    .CLK_HZ    (10),
    .TIME_LIMIT(3),
    .HOLD_SEC  (2)
  ) dut (
    .CLK      (CLK),
    .RST      (RST),
    .RUN_IN   (RUN_IN),
    .NUM      (NUM),
    .ANS_VALID(ANS_VALID),
    .ANS      (ANS),
    .STATE    (STATE),
    .TARGET   (TARGET),
    .REMAIN   (REMAIN),
    .SEC_LEFT (SEC_LEFT),
    .HIT      (HIT)
  );

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic answer(input logic [3:0] a);
    ANS       = a;
    ANS_VALID = 1'b1;
    step();
    ANS_VALID = 1'b0;
  endtask

  task automatic start_round(input logic [3:0] num, input logic [4:0] tgt);
    RUN_IN = 1'b0;
    step();
    NUM    = num;
    RUN_IN = 1'b1;
    step();
    chk("load_state", STATE, 32'd1);
    step();
    chk("play_state", STATE, 32'd2);
    chk("target", TARGET, tgt);
    chk("remain_init", REMAIN, tgt);
    chk("sec_init", SEC_LEFT, 32'd3);
  endtask

  task automatic back_to_idle(input int n);
    repeat (n) step();
    chk("return_idle", STATE, 32'd0);
  endtask

  initial begin
    logic [3:0] bad [3];
    bad[0] = 4'd2;
    bad[1] = 4'd9;
    bad[2] = 4'd1;

    RST       = 1'b0;
    RUN_IN    = 1'b0;
    NUM       = 4'd0;
    ANS_VALID = 1'b0;
    ANS       = 4'd0;
    #12;
    chk("rst_state", STATE, 32'd0);
    chk("rst_target", TARGET, 32'd0);
    chk("rst_remain", REMAIN, 32'd0);
    chk("rst_sec", SEC_LEFT, 32'd0);
    chk("rst_hit", HIT, 32'd0);
    step();
    RST = 1'b1;
    step();

    // Win path: 12 = 2*2*3
    start_round(4'd5, 5'd12);
    answer(4'd2);
    chk("win_rem6", REMAIN, 32'd6);
    chk("win_hit1", HIT, 32'd1);
    chk("win_play1", STATE, 32'd2);
    step();
    chk("win_hit1_clr", HIT, 32'd0);
    answer(4'd2);
    chk("win_rem3", REMAIN, 32'd3);
    chk("win_hit2", HIT, 32'd1);
    step();
    answer(4'd3);
    chk("win_rem1", REMAIN, 32'd1);
    chk("win_hit3", HIT, 32'd1);
    chk("win_state", STATE, 32'd3);
    answer(4'd2);
    chk("win_ans_ignored_state", STATE, 32'd3);
    chk("win_ans_ignored_rem", REMAIN, 32'd1);
    chk("win_ans_ignored_hit", HIT, 32'd0);
    RUN_IN = 1'b0;
    step();
    RUN_IN = 1'b1;
    step();
    chk("win_run_ignored", STATE, 32'd3);
    repeat (16) step();
    chk("win_hold_19", STATE, 32'd3);
    step();
    chk("win_idle_20", STATE, 32'd0);

    // Wrong factors: non-divisor, composite, one
    for (int i = 0; i < 3; i++) begin
      start_round(4'd3, 5'd9);
      answer(bad[i]);
      chk("wrong_state", STATE, 32'd4);
      chk("wrong_remain", REMAIN, 32'd9);
      chk("wrong_hit", HIT, 32'd0);
      back_to_idle(20);
    end

    // Timeout
    start_round(4'd0, 5'd4);
    for (int c = 1; c <= 30; c++) begin
      step();
      if (c == 9)  chk("to_sec3", SEC_LEFT, 32'd3);
      if (c == 10) chk("to_sec2", SEC_LEFT, 32'd2);
      if (c == 20) chk("to_sec1", SEC_LEFT, 32'd1);
      if (c == 29) chk("to_play29", STATE, 32'd2);
      if (c == 30) begin
        chk("to_sec0", SEC_LEFT, 32'd0);
        chk("to_lose30", STATE, 32'd4);
        chk("to_remain", REMAIN, 32'd4);
      end
    end
    back_to_idle(20);

    // Final factor coinciding with the terminal tick wins
    start_round(4'd0, 5'd4);
    answer(4'd2);
    chk("sim_win_rem2", REMAIN, 32'd2);
    repeat (28) step();
    chk("sim_win_sec1", SEC_LEFT, 32'd1);
    chk("sim_win_play", STATE, 32'd2);
    answer(4'd2);
    chk("sim_win_state", STATE, 32'd3);
    chk("sim_win_rem1", REMAIN, 32'd1);
    chk("sim_win_sec", SEC_LEFT, 32'd1);
    chk("sim_win_hit", HIT, 32'd1);
    back_to_idle(20);

    // Non-final factor on the terminal tick loses but still hits
    start_round(4'd5, 5'd12);
    repeat (29) step();
    answer(4'd2);
    chk("sim_lose_state", STATE, 32'd4);
    chk("sim_lose_rem", REMAIN, 32'd6);
    chk("sim_lose_sec", SEC_LEFT, 32'd0);
    chk("sim_lose_hit", HIT, 32'd1);
    step();
    chk("sim_lose_hit_clr", HIT, 32'd0);
    back_to_idle(19);

    // NUM above 9 folds onto the table, then ANS_VALID in IDLE changes nothing
    start_round(4'd12, 5'd8);
    answer(4'd7);
    chk("n12_lose", STATE, 32'd4);
    chk("n12_remain", REMAIN, 32'd8);
    back_to_idle(20);
    answer(4'd2);
    chk("idle_ans_state", STATE, 32'd0);
    chk("idle_ans_remain", REMAIN, 32'd8);
    chk("idle_ans_target", TARGET, 32'd8);
    chk("idle_ans_sec", SEC_LEFT, 32'd3);
    chk("idle_ans_hit", HIT, 32'd0);

    // Reset mid-round with RUN_IN held high through release
    start_round(4'd7, 5'd15);
    answer(4'd3);
    chk("mid_rem5", REMAIN, 32'd5);
    #2;
    RST = 1'b0;
    #1;
    chk("mid_rst_state", STATE, 32'd0);
    chk("mid_rst_target", TARGET, 32'd0);
    chk("mid_rst_remain", REMAIN, 32'd0);
    chk("mid_rst_sec", SEC_LEFT, 32'd0);
    chk("mid_rst_hit", HIT, 32'd0);
    step();
    RST = 1'b1;
    repeat (3) step();
    chk("run_high_no_start", STATE, 32'd0);

    // Normal round after reset, NUM=15 folds to index 5
    start_round(4'd15, 5'd12);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
